// File: rtl/cache_line_xfer_ctrl_pkg.sv
// Shared types and default geometry for the cache line transfer controller.
package cache_line_xfer_ctrl_pkg;

    // Data RAM geometry: beats of a line map onto distinct RAM splits.
    localparam int N_DATA_RAM_SPLIT   = 8;
    localparam int BANK_INDEX_WIDTH   = 12;

    localparam int DEF_BEATS          = N_DATA_RAM_SPLIT;
    localparam int DEF_LINE_IDX_WIDTH = BANK_INDEX_WIDTH - $clog2(N_DATA_RAM_SPLIT);
    localparam int DEF_DATA_WIDTH     = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        EVICT = 2'd2,
        DONE  = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/cache_xfer_skid_fifo.sv
// Two-entry skid buffer holding evict beats read from the data RAM,
// each tagged with whether it is the final beat of the line.
module cache_xfer_skid_fifo #(
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_last,
    input  logic                  pop,
    output logic [1:0]            count,
    output logic                  head_valid,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last
);

    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];
    logic [1:0]            last_q, last_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  do_pop;

    // Pointer/count update; push and pop in the same cycle are both honoured.
    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        data_d   = data_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            data_d[wr_ptr_q] = push_data;
            last_d[wr_ptr_q] = push_last;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, do_pop};
    end

    // Storage and control registers; payload needs no reset, tags and pointers do.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        if (rst) begin
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            last_q   <= last_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != 2'd0);
    assign head_data  = data_q[rd_ptr_q];
    assign head_last  = head_valid && last_q[rd_ptr_q];

endmodule

// File: rtl/cache_line_xfer_ctrl.sv
// Whole-line refill/evict sequencer between the memory-side bus and the
// cache data RAM's memory-controller port.
module cache_line_xfer_ctrl
    import cache_line_xfer_ctrl_pkg::*;
#(
    parameter int BEATS          = DEF_BEATS,
    parameter int LINE_IDX_WIDTH = DEF_LINE_IDX_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    localparam int BEAT_W        = $clog2(BEATS),
    localparam int CNT_W         = BEAT_W + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_rw,
    input  logic [LINE_IDX_WIDTH-1:0]        req_line_idx,
    input  logic                             fill_valid,
    output logic                             fill_ready,
    input  logic [DATA_WIDTH-1:0]            fill_data,
    output logic                             evict_valid,
    input  logic                             evict_ready,
    output logic [DATA_WIDTH-1:0]            evict_data,
    output logic                             evict_last,
    output logic                             done,
    output logic                             busy,
    output logic                             mc_en,
    output logic                             mc_rw,
    output logic [LINE_IDX_WIDTH+BEAT_W-1:0] mc_bank_index,
    output logic [DATA_WIDTH-1:0]            mc_din,
    input  logic                             mc_ready,
    input  logic [DATA_WIDTH-1:0]            mc_dout
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] N_BEATS   = CNT_W'(BEATS);

    xfer_state_e               state_q, state_d;
    logic [LINE_IDX_WIDTH-1:0] line_q, line_d;
    logic [CNT_W-1:0]          wr_beat_q, wr_beat_d;
    logic [CNT_W-1:0]          rd_beat_q, rd_beat_d;
    logic                      inflight_q, inflight_d;
    logic                      inflight_last_q, inflight_last_d;

    logic                      fill_fire;
    logic                      rd_issue;
    logic                      pop;
    logic [2:0]                credit_used;
    logic [1:0]                fifo_count;
    logic                      fifo_valid;
    logic                      fifo_last;
    logic [DATA_WIDTH-1:0]     fifo_data;

    // State and counter registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            line_q          <= '0;
            wr_beat_q       <= '0;
            rd_beat_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            line_q          <= line_d;
            wr_beat_q       <= wr_beat_d;
            rd_beat_q       <= rd_beat_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    // Next-state and beat-counter logic.
    always_comb begin
        state_d         = state_q;
        line_d          = line_q;
        wr_beat_d       = wr_beat_q;
        rd_beat_d       = rd_beat_q;
        inflight_d      = rd_issue;
        inflight_last_d = rd_issue && (rd_beat_q == LAST_BEAT);
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    line_d    = req_line_idx;
                    wr_beat_d = '0;
                    rd_beat_d = '0;
                    state_d   = req_rw ? FILL : EVICT;
                end
            end
            FILL: begin
                if (fill_fire) begin
                    wr_beat_d = wr_beat_q + 1'b1;
                    if (wr_beat_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end
            EVICT: begin
                if (rd_issue) begin
                    rd_beat_d = rd_beat_q + 1'b1;
                end
                if (pop && fifo_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: handshakes and RAM port driven from the current state.
    always_comb begin
        req_ready   = (state_q == IDLE);
        busy        = (state_q == FILL) || (state_q == EVICT);
        done        = (state_q == DONE);
        fill_ready  = (state_q == FILL) && mc_ready;
        fill_fire   = fill_ready && fill_valid;
        evict_valid = fifo_valid;
        evict_data  = fifo_data;
        evict_last  = fifo_last;
        pop         = fifo_valid && evict_ready;
        // Slots committed after this edge: the beat popped now frees its slot,
        // which is what lets reads stream at one per cycle without overflow.
        credit_used = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
        rd_issue    = (state_q == EVICT) && (rd_beat_q < N_BEATS) && mc_ready &&
                      (credit_used < 3'd2);
        mc_en       = fill_fire || rd_issue;
        mc_rw       = fill_fire;
        mc_din      = fill_fire ? fill_data : '0;
        if (fill_fire) begin
            mc_bank_index = {line_q, wr_beat_q[BEAT_W-1:0]};
        end else if (rd_issue) begin
            mc_bank_index = {line_q, rd_beat_q[BEAT_W-1:0]};
        end else begin
            mc_bank_index = '0;
        end
    end

    // Read data lands one cycle after issue and is parked in the skid buffer.
    cache_xfer_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (mc_dout),
        .push_last (inflight_last_q),
        .pop       (pop),
        .count     (fifo_count),
        .head_valid(fifo_valid),
        .head_data (fifo_data),
        .head_last (fifo_last)
    );

endmodule

// File: tb/tb_cache_line_xfer_ctrl.sv
// Directed bench for cache_line_xfer_ctrl with a behavioural data RAM.
module tb_cache_line_xfer_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_rw;
    logic [8:0]   req_line_idx;
    logic         fill_valid, fill_ready;
    logic [255:0] fill_data;
    logic         evict_valid, evict_ready, evict_last;
    logic [255:0] evict_data;
    logic         done, busy;
    logic         mc_en, mc_rw, mc_ready;
    logic [11:0]  mc_bank_index;
    logic [255:0] mc_din;
    logic [255:0] mc_dout;

    logic [255:0] mem [0:4095];

    int checks   = 0;
    int failures = 0;

    cache_line_xfer_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_rw       (req_rw),
        .req_line_idx (req_line_idx),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_data    (fill_data),
        .evict_valid  (evict_valid),
        .evict_ready  (evict_ready),
        .evict_data   (evict_data),
        .evict_last   (evict_last),
        .done         (done),
        .busy         (busy),
        .mc_en        (mc_en),
        .mc_rw        (mc_rw),
        .mc_bank_index(mc_bank_index),
        .mc_din       (mc_din),
        .mc_ready     (mc_ready),
        .mc_dout      (mc_dout)
    );

    always #5 clk = ~clk;

    // Data RAM: writes take effect at the edge, reads return one cycle later.
    always @(posedge clk) begin
        if (mc_en && mc_ready) begin
            if (mc_rw) mem[mc_bank_index] <= mc_din;
            else       mc_dout <= mem[mc_bank_index];
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] fill_pat(input int t, input int b);
        logic [7:0] t8 = 8'(t);
        logic [7:0] b8 = 8'(b);
        return {8{t8, 8'hC5, b8, 8'h3A}};
    endfunction

    function automatic logic [255:0] ev_pat(input int line, input int b);
        logic [7:0] l8 = 8'(line);
        logic [7:0] b8 = 8'(b);
        if (line == 3) return 256'(b * 17);
        return {8{l8, 8'h5A, b8, 8'hE1}};
    endfunction

    // Bench-side step: one clock later, 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // After the last beat: DONE for one cycle, then back to IDLE.
    task automatic check_done_then_idle(input string tag);
        @(negedge clk);
        check_eq({tag, "_done"}, {done, busy, req_ready, mc_en, fill_ready, evict_valid}, 6'b100000);
        step();
        @(negedge clk);
        check_eq({tag, "_idle"}, {done, busy, req_ready, mc_en, fill_ready, evict_valid}, 6'b001000);
        step();
    endtask

    task automatic run_fill(input int line, input int t, input logic [31:0] vld_pat,
                            input logic [31:0] rdy_pat, input bit poke);
        int   wb = 0;
        int   c  = 0;
        logic en_exp;
        req_valid = 1'b1; req_rw = 1'b1; req_line_idx = 9'(line);
        @(negedge clk);
        check_eq("fill_accept", req_ready, 1'b1);
        step();
        req_valid = poke; req_rw = 1'b0;
        while (wb < 8 && c < 32) begin
            fill_valid = vld_pat[c];
            mc_ready   = rdy_pat[c];
            fill_data  = fill_pat(t, wb);
            @(negedge clk);
            en_exp = fill_valid && mc_ready;
            check_eq("fill_ready", fill_ready, mc_ready);
            check_eq("fill_mc_en", mc_en, en_exp);
            check_eq("fill_busy_noreq", {busy, req_ready}, 2'b10);
            if (en_exp) begin
                check_eq("fill_mc_rw", mc_rw, 1'b1);
                check_eq("fill_idx", mc_bank_index, 12'(line * 8 + wb));
                check_eq("fill_din", mc_din, fill_pat(t, wb));
            end
            step();
            if (en_exp) wb++;
            c++;
        end
        fill_valid = 1'b0; mc_ready = 1'b1; req_valid = 1'b0;
        check_eq("fill_beats", wb, 8);
        check_done_then_idle("fill");
        $display("refill line %0d: %0d beats in %0d cycles", line, wb, c);
    endtask

    task automatic run_evict(input int line, input logic [31:0] rdy_pat,
                             input int exp_last_pop, input int abort_at);
        int   rb = 0;
        int   ib = 0;
        int   c  = 0;
        int   last_pop = -1;
        logic p, en;
        req_valid = 1'b1; req_rw = 1'b0; req_line_idx = 9'(line);
        @(negedge clk);
        check_eq("ev_accept", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        while (rb < abort_at && c < 40) begin
            evict_ready = (c < 32) ? rdy_pat[c] : 1'b1;
            @(negedge clk);
            p  = evict_valid && evict_ready;
            en = mc_en;
            if (c < 2)  check_eq("ev_early_valid", evict_valid, 1'b0);
            if (c == 2) check_eq("ev_first_valid", evict_valid, 1'b1);
            if (evict_valid) begin
                check_eq("ev_data", evict_data, ev_pat(line, rb));
                check_eq("ev_last", evict_last, (rb == 7));
            end
            if (en) begin
                check_eq("ev_mc_rw", mc_rw, 1'b0);
                check_eq("ev_idx", mc_bank_index, 12'(line * 8 + ib));
                check_eq("ev_credit", ((ib - rb - int'(p)) < 2), 1'b1);
            end
            if (p && rb == 7) last_pop = c;
            step();
            if (p)  rb++;
            if (en) ib++;
            c++;
        end
        evict_ready = 1'b0;
        if (abort_at == 8) begin
            check_eq("ev_beats", rb, 8);
            check_eq("ev_reads", ib, 8);
            check_eq("ev_last_pop_cycle", last_pop, exp_last_pop);
            check_done_then_idle("ev");
        end
        $display("evict line %0d: %0d beats popped in %0d cycles", line, rb, c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int l = 0; l < 16; l++)
            for (int b = 0; b < 8; b++)
                mem[l * 8 + b] = ev_pat(l, b);
        mc_dout = '0;
        rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_line_idx = '0;
        fill_valid = 1'b0; fill_data = '0; evict_ready = 1'b0; mc_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check_eq("reset_outputs",
                 {req_ready, busy, done, fill_ready, evict_valid, evict_last, mc_en, mc_rw},
                 8'b1000_0000);
        step();
        rst = 1'b0;
        step();

        // Refill line 5 back-to-back.
        run_fill(5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        // Refill line 6 with fill_valid on alternate cycles, stray request held high.
        run_fill(6, 2, 32'h5555_5555, 32'hFFFF_FFFF, 1'b1);
        // Refill line 7 with RAM stalled for cycles 3..5.
        run_fill(7, 3, 32'hFFFF_FFFF, ~32'h0000_0038, 1'b0);
        // Evict line 3 without backpressure: pops on cycles 2..9.
        run_evict(3, 32'hFFFF_FFFF, 9, 8);
        // Evict line 9 with evict_ready low for cycles 4..8.
        run_evict(9, ~32'h0000_01F0, 14, 8);
        // Evict line 4, reset after four beats have been delivered.
        run_evict(4, 32'hFFFF_FFFF, 0, 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_outputs",
                 {req_ready, busy, done, fill_ready, evict_valid, evict_last, mc_en, mc_rw},
                 8'b1000_0000);
        step();
        @(negedge clk);
        check_eq("abort_no_done", {done, mc_en, evict_valid}, 3'b000);
        step();
        run_fill(2, 4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_line_xfer_ctrl.md
Name: cache_line_xfer_ctrl

Overview:
- Sequences whole-line transfers between the memory-side bus and the cache data RAM's memory-controller port (mc_*).
- Refill: accepts BEATS beats from the bus and writes them into consecutive bank indices of one line.
- Evict: reads BEATS beats, absorbs the RAM's fixed 1-cycle read latency, and streams them out with valid/ready backpressure.
- Sits between the cache miss/writeback logic and the data RAM; one transfer in flight at a time.

Parameters:
- BEATS, 8, beats per line (power of 2; beat index occupies bank_index low bits, so consecutive beats hit different RAM splits)
- LINE_IDX_WIDTH, 9, width of line index
- DATA_WIDTH, 256, beat width (equals RAM port width)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  transfer request
- req_ready  out  1  controller idle, request accepted when both high
- req_rw  in  1  1 = refill (write RAM), 0 = evict (read RAM)
- req_line_idx  in  LINE_IDX_WIDTH  target line
- fill_valid  in  1  refill beat valid
- fill_ready  out  1  refill beat accepted
- fill_data  in  DATA_WIDTH  refill beat
- evict_valid  out  1  evict beat valid
- evict_ready  in  1  downstream accepts evict beat
- evict_data  out  DATA_WIDTH  evict beat
- evict_last  out  1  marks final evict beat
- done  out  1  one-cycle pulse at transfer completion
- busy  out  1  transfer in progress
- mc_en  out  1  RAM access enable
- mc_rw  out  1  1 = write
- mc_bank_index  out  LINE_IDX_WIDTH+log2(BEATS)  {line_idx, beat}
- mc_din  out  DATA_WIDTH  write data
- mc_ready  in  1  RAM accepts access this cycle
- mc_dout  in  DATA_WIDTH  read data, valid the cycle after an accepted read

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, busy=0, done=0, fill_ready=0, evict_valid=0, evict_last=0, mc_en=0, mc_rw=0, beat counters 0, buffer empty. Reset mid-transfer aborts it: no done pulse, no further mc_en.
- States:
  - IDLE: req_ready=1. On req_valid: latch line_idx, clear counters, go to FILL (rw=1) or EVICT (rw=0).
  - FILL: fill_ready = mc_ready. When fill_valid & mc_ready: mc_en=1, mc_rw=1, mc_din=fill_data, mc_bank_index={line, wr_beat}, wr_beat++. mc_en is combinational from fill_valid, so there is no added latency. After beat BEATS-1 is written, go to DONE.
  - EVICT:
    - Issue a read (mc_en=1, mc_rw=0, index {line, rd_beat}) when rd_beat < BEATS, mc_ready=1, and buf_count + inflight < 2.
    - inflight is a 1-bit register, set the cycle after an issue. On the next cycle mc_dout is captured into a 2-entry FIFO (skid buffer).
    - evict_valid = FIFO non-empty; evict_data = FIFO head; evict_last = head is beat BEATS-1.
    - Capture and pop in the same cycle are legal.
    - When the last beat pops (evict_valid & evict_ready & evict_last), go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0 next, then IDLE. req_ready=0 in DONE.
- busy=1 in FILL and EVICT.
- Throughput: with no stalls, FILL moves 1 beat/cycle. EVICT has first evict_valid 2 cycles after entering EVICT, then 1 beat/cycle.
- Backpressure: the FIFO never overflows. Credit rule guarantees capacity for every in-flight read. evict_data is stable while evict_valid & ~evict_ready.
- Counters are log2(BEATS)+1 bits; beat index is the low log2(BEATS) bits. No wrap past BEATS.
- mc_en is never asserted in IDLE or DONE.
- req_valid in a non-IDLE state is ignored (req_ready=0).

Decomposition:
- Shared package holds: xfer_state_e (IDLE, FILL, EVICT, DONE) and the default BEATS/LINE_IDX_WIDTH constants tied to N_DATA_RAM_SPLIT and BANK_INDEX_WIDTH.
- One sub-module: cache_xfer_skid_fifo, a 2-entry DATA_WIDTH FIFO with push/pop/count and a last-tag bit.

Test Plan:
- Refill line 5, fill_valid held high: mc_en high 8 consecutive cycles, mc_bank_index 0x28..0x2F, mc_din = fill beats in order, done one cycle after the last write.
- Refill with fill_valid low on alternate cycles: writes occur only on valid cycles, indices contiguous, done after the 8th write.
- Evict line 3, RAM preloaded with pattern beat*0x11, evict_ready=1: evict_valid from cycle 2 after accept, 8 consecutive beats in order, evict_last on the 8th, done the cycle after.
- Evict with evict_ready low for 5 cycles mid-stream: data held stable, no reads issued while buf_count + inflight = 2, no beat lost or duplicated.
- mc_ready low for 3 cycles during a refill: fill_ready low and no mc_en during the stall, transfer resumes correctly.
- rst asserted at beat 4 of an evict: next cycle all outputs at reset values, no done. A new refill request is then accepted and completes normally.
